rle_compressor: RTL
===================

Name: rle_compressor

Overview:
- Optional run-length compressor between data_composer (16-bit composed words, stb) and fifo_16 (sample FIFO), in the CLK300MHZ domain.
- Collapses consecutive identical composed words into {value, run_length} word pairs to extend effective capture depth.
- In bypass mode it forwards words unchanged.
- A small internal output queue absorbs the 2-words-per-run burst; downstream backpressure is ack_in (driven from !fifo_16_full).

Parameters:
- MAX_RUN, 16'hFFFF, maximum run length before a forced pair emission (2..65535).
- Q_DEPTH, 8, output queue depth in words (power of 2, >=4).

Ports:
- CLK300MHZ  in  1  sampling clock.
- RST  in  1  reset, asynchronous, active-high.
- EN  in  1  capture enable; stb_in is ignored while low.
- rle_en  in  1  1 = compress, 0 = bypass; latched on EN rising edge.
- data_in  in  16  composed sample word.
- stb_in  in  1  data_in valid, single-cycle, at most one per clock.
- flush  in  1  pulse: emit the pending run.
- ack_in  in  1  downstream can accept data_out this cycle.
- data_out  out  16  queue head word.
- stb_out  out  1  data_out valid (queue non-empty).
- overflow  out  1  sticky: a word or pair was dropped.
- run_pending  out  1  a run is held and not yet emitted.

Behaviour:
- Reset (async): queue empty, state EMPTY, mode latch = 0, all outputs 0. cur_val and cur_cnt cleared.
- Run state machine, EMPTY / RUN, active when mode = compress:
  - EMPTY + accepted stb_in: cur_val = data_in, cur_cnt = 1, go to RUN.
  - RUN + stb_in, data_in == cur_val, cur_cnt < MAX_RUN: cur_cnt + 1.
  - RUN + stb_in, data_in == cur_val, cur_cnt == MAX_RUN: emit pair (cur_val, MAX_RUN); new run with cur_cnt = 1, same value.
  - RUN + stb_in, data_in != cur_val: emit pair (cur_val, cur_cnt); new run with data_in, cur_cnt = 1.
  - RUN + flush (no stb_in): emit pair, go to EMPTY.
  - flush + stb_in in the same cycle: stb_in is processed first; flush is deferred one cycle via an internal pending bit.
  - EMPTY + flush: no action.
  - EN falling edge: acts as flush.
- Pair emission writes two words at one clock edge: value first, then count (16-bit, zero-extended).
- Bypass mode: each accepted stb_in enqueues data_in as one word. The run FSM stays EMPTY and flush has no effect.
- rle_en is latched only on the EN rising edge; changes while EN is high are ignored.
- run_pending = (state == RUN).
- Queue:
  - FWFT: stb_out = (count != 0), data_out = head register.
  - A word pops at a clock edge when stb_out && ack_in. At most 1 pop and at most 2 pushes per cycle.
  - Admission uses the start-of-cycle count only; a same-cycle pop is not credited.
  - A pair is admitted if count <= Q_DEPTH-2; otherwise the whole pair is dropped (never split) and overflow is set.
  - A bypass word is admitted if count <= Q_DEPTH-1; otherwise it is dropped and overflow is set.
  - overflow is cleared only by RST.
  - When a run is lost to overflow, the FSM still starts the new run, so a dropped pair never stalls the state machine.
  - Pointers wrap modulo Q_DEPTH.
- Latency:
  - An event at edge k (terminating stb_in, flush, or bypass stb_in) writes the queue at edge k+1.
  - stb_out is visible in the cycle after edge k+1 when the queue was previously empty.
- Runs never span an EN low period; the pending run is always flushed on EN fall.
- RST mid-run discards the held run and the queue contents.

Test Plan:
- Compress, ack_in = 1: samples 0x00AA x4, 0x0055 x2, 0x1234 x1, then flush -> stb_out words 0x00AA, 0x0004, 0x0055, 0x0002, 0x1234, 0x0001; run_pending = 0 afterwards; overflow = 0.
- MAX_RUN = 4: 10 consecutive 0xBEEF then flush -> BEEF/0004, BEEF/0004, BEEF/0002.
- Bypass (rle_en = 0 at EN rise), 6 back-to-back words 0x0001..0x0006 -> same 6 words in order, each exactly once; flush ignored.
- Q_DEPTH = 8, ack_in = 0, compress, alternating 0x0000/0xFFFF for 6 samples:
  - First 4 pairs (8 words) are queued; 5th pair dropped, overflow = 1.
  - Raise ack_in -> exactly 8 words drain, first 0x0000, 0x0001.
- flush and stb_in (0x0007, differing from the held 0x0003 x2) in the same cycle -> 0003/0002 then 0007/0001, with the second pair one cycle later.
- Assert RST asynchronously mid-run with 3 words queued -> stb_out, overflow, run_pending go to 0 immediately; the next run starts clean.

Source files
------------

// File: rtl/rle_compressor.sv
// rle_compressor
//   Optional run-length compressor sitting between data_composer and fifo_16
//   in the CLK300MHZ domain. In compress mode, consecutive identical 16-bit
//   words collapse into {value, run_length} pairs. In bypass mode, words pass
//   through unchanged. A small FWFT output queue absorbs the two-word burst
//   that each run produces.
//
// Ports
//   CLK300MHZ   sampling clock
//   RST         asynchronous active-high reset
//   EN          capture enable; stb_in is ignored while low, and a fall flushes
//   rle_en      1 = compress, 0 = bypass (latched on the EN rising edge)
//   data_in     composed sample word
//   stb_in      data_in valid, single-cycle
//   flush       pulse: emit the pending run
//   ack_in      downstream can accept data_out this cycle
//   data_out    queue head word
//   stb_out     data_out valid (queue non-empty)
//   overflow    sticky: a word or pair was dropped
//   run_pending a run is held and not yet emitted
module rle_compressor #(
  parameter logic [15:0] MAX_RUN = 16'hFFFF,
  parameter int unsigned Q_DEPTH = 8
) (
  input  logic        CLK300MHZ,
  input  logic        RST,
  input  logic        EN,
  input  logic        rle_en,
  input  logic [15:0] data_in,
  input  logic        stb_in,
  input  logic        flush,
  input  logic        ack_in,
  output logic [15:0] data_out,
  output logic        stb_out,
  output logic        overflow,
  output logic        run_pending
);

  localparam int unsigned AW = $clog2(Q_DEPTH);
  localparam logic [AW:0] C_PAIR_LIM = (AW+1)'(Q_DEPTH - 2);
  localparam logic [AW:0] C_WORD_LIM = (AW+1)'(Q_DEPTH - 1);

  typedef enum logic {S_EMPTY, S_RUN} state_t;

  // Run FSM and mode tracking
  state_t      r_state;
  logic [15:0] r_val;
  logic [15:0] r_cnt;
  logic        r_flush_pend;
  logic        r_en_d;
  logic        r_mode;

  // One-cycle emission stage between the FSM and the queue
  logic [1:0]  r_push_n;
  logic [15:0] r_w0;
  logic [15:0] r_w1;

  // Output queue
  logic [15:0] r_mem [Q_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_qcnt;
  logic          r_ovf;

  state_t      w_state_nxt;
  logic [15:0] w_val_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_pend_nxt;
  logic [1:0]  w_push_n;
  logic [15:0] w_w0;
  logic [15:0] w_w1;

  logic w_en_rise;
  logic w_en_fall;
  logic w_mode;
  logic w_stb;
  logic w_flush_req;
  logic w_pop;
  logic w_push_ok;
  logic [1:0] w_nq;

  assign w_en_rise   = EN & ~r_en_d;
  assign w_en_fall   = ~EN & r_en_d;
  // A strobe in the same cycle as the EN rise already uses the new mode.
  assign w_mode      = w_en_rise ? rle_en : r_mode;
  assign w_stb       = EN & stb_in;
  // EN fall and a deferred flush behave exactly like an external flush.
  assign w_flush_req = flush | r_flush_pend | w_en_fall;

  always_comb begin
    w_state_nxt = r_state;
    w_val_nxt   = r_val;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = 1'b0;
    w_push_n    = 2'd0;
    w_w0        = r_val;
    w_w1        = r_cnt;
    if (!w_mode) begin
      w_state_nxt = S_EMPTY;
      if (w_stb) begin
        w_push_n = 2'd1;
        w_w0     = data_in;
      end
    end else if (w_stb) begin
      // The sample wins; any flush this cycle is retried next cycle.
      w_pend_nxt = w_flush_req;
      if (r_state == S_EMPTY) begin
        w_state_nxt = S_RUN;
        w_val_nxt   = data_in;
        w_cnt_nxt   = 16'd1;
      end else if (data_in == r_val && r_cnt != MAX_RUN) begin
        w_cnt_nxt = r_cnt + 16'd1;
      end else begin
        w_push_n  = 2'd2;
        w_val_nxt = data_in;
        w_cnt_nxt = 16'd1;
      end
    end else if (w_flush_req && r_state == S_RUN) begin
      w_push_n    = 2'd2;
      w_state_nxt = S_EMPTY;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge CLK300MHZ or posedge RST) begin
    if (RST) begin
      r_state      <= S_EMPTY;
      r_val        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_en_d       <= 1'b0;
      r_mode       <= 1'b0;
      r_push_n     <= 2'd0;
      r_w0         <= '0;
      r_w1         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_val        <= w_val_nxt;
      r_cnt        <= w_cnt_nxt;
      r_flush_pend <= w_pend_nxt;
      r_en_d       <= EN;
      if (w_en_rise) r_mode <= rle_en;
      r_push_n     <= w_push_n;
      r_w0         <= w_w0;
      r_w1         <= w_w1;
    end
  end

  // Admission looks only at the start-of-cycle occupancy; a pair is
  // admitted or dropped as a whole.
  assign w_pop = (r_qcnt != '0) & ack_in;

  always_comb begin
    w_push_ok = 1'b0;
    case (r_push_n)
      2'd1:    w_push_ok = (r_qcnt <= C_WORD_LIM);
      2'd2:    w_push_ok = (r_qcnt <= C_PAIR_LIM);
      default: w_push_ok = 1'b0;
    endcase
  end

  assign w_nq = w_push_ok ? r_push_n : 2'd0;

  always_ff @(posedge CLK300MHZ or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < Q_DEPTH; i++) r_mem[i] <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_qcnt <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wp] <= r_w0;
        if (r_push_n == 2'd2) r_mem[r_wp + AW'(1)] <= r_w1;
      end
      if (r_push_n != 2'd0 && !w_push_ok) r_ovf <= 1'b1;
      r_wp   <= r_wp + AW'(w_nq);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_qcnt <= r_qcnt + (AW+1)'(w_nq) - (AW+1)'(w_pop);
    end
  end

  assign data_out    = r_mem[r_rp];
  assign stb_out     = (r_qcnt != '0);
  assign overflow    = r_ovf;
  assign run_pending = (r_state == S_RUN);

endmodule
